ehl_jtag_tap: RTL and testbench

//  IEEE 1149.1 TAP controller: 16-state TMS-driven FSM, instruction register (IR), BYPASS/IDCODE DRs, TDO mux.

---
 rtl/ehl_jtag_tap.sv | 150 +++++++++++++++
 tb/tb_ehl_jtag_tap.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ehl_jtag_tap.sv
// ehl_jtag_tap: IEEE 1149.1 TAP controller (FSM, IR, BYPASS/IDCODE DRs, TDO mux) sequencing the BSC chain.
// Latency: strobes decode the registered state; TDO updates on the falling tck edge. No backpressure (tck-paced).
// Optional 32-bit ID register and IDCODE reset instruction enabled by `define EHL_JTAG_IDCODE_EN.
module ehl_jtag_tap #(
  parameter int                  IR_WIDTH  = 4,
  parameter logic [IR_WIDTH-1:0] OP_EXTEST = IR_WIDTH'(0),
  parameter logic [IR_WIDTH-1:0] OP_SAMPLE = IR_WIDTH'(1),
  parameter logic [IR_WIDTH-1:0] OP_INTEST = IR_WIDTH'(2),
  parameter logic [IR_WIDTH-1:0] OP_IDCODE = IR_WIDTH'(3),
  parameter logic [31:0]         IDCODE    = 32'h1000_0001
) (
  input  logic tck,
  input  logic trst_n,
  input  logic tms,
  input  logic tdi,
  output logic tdo,
  output logic tdo_en,
  input  logic bsr_so,
  output logic capture_dr,
  output logic shift_dr,
  output logic update_dr,
  output logic extest,
  output logic intest
);

  typedef enum logic [3:0] {
    TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR
  } state_e;

`ifdef EHL_JTAG_IDCODE_EN
  localparam bit                  ID_EN  = 1'b1;
  localparam logic [IR_WIDTH-1:0] RST_OP = OP_IDCODE;
`else
  // Without the ID register the IDCODE opcode falls through to BYPASS.
  localparam bit                  ID_EN  = 1'b0;
  localparam logic [IR_WIDTH-1:0] RST_OP = '1;
`endif

  localparam logic [IR_WIDTH-1:0] IR_CAP = IR_WIDTH'(2'b01);

  state_e              state_q, state_d;
  logic [IR_WIDTH-1:0] ir_q, ir_d;
  logic [IR_WIDTH-1:0] ir_shift_q, ir_shift_d;
  logic                bypass_q, bypass_d;
  logic [31:0]         id_q, id_d;
  logic                tdo_q, tdo_d;
  logic                tdo_en_q, tdo_en_d;

  logic bsr_sel, id_sel, byp_sel;

  assign bsr_sel = (ir_q == OP_EXTEST) || (ir_q == OP_SAMPLE) || (ir_q == OP_INTEST);
  assign id_sel  = ID_EN && (ir_q == OP_IDCODE);
  assign byp_sel = !bsr_sel && !id_sel;

  always_comb begin
    state_d = state_q;
    case (state_q)
      TLR:    state_d = tms ? TLR    : RTI;
      RTI:    state_d = tms ? SEL_DR : RTI;
      SEL_DR: state_d = tms ? SEL_IR : CAP_DR;
      CAP_DR: state_d = tms ? EX1_DR : SH_DR;
      SH_DR:  state_d = tms ? EX1_DR : SH_DR;
      EX1_DR: state_d = tms ? UPD_DR : PA_DR;
      PA_DR:  state_d = tms ? EX2_DR : PA_DR;
      EX2_DR: state_d = tms ? UPD_DR : SH_DR;
      UPD_DR: state_d = tms ? SEL_DR : RTI;
      SEL_IR: state_d = tms ? TLR    : CAP_IR;
      CAP_IR: state_d = tms ? EX1_IR : SH_IR;
      SH_IR:  state_d = tms ? EX1_IR : SH_IR;
      EX1_IR: state_d = tms ? UPD_IR : PA_IR;
      PA_IR:  state_d = tms ? EX2_IR : PA_IR;
      EX2_IR: state_d = tms ? UPD_IR : SH_IR;
      UPD_IR: state_d = tms ? SEL_DR : RTI;
    endcase
  end

  // Instruction only moves in TLR/UPD_IR, so extest/intest hold through every DR state.
  always_comb begin
    ir_d       = ir_q;
    ir_shift_d = ir_shift_q;
    bypass_d   = bypass_q;
    id_d       = id_q;
    case (state_q)
      TLR:    ir_d       = RST_OP;
      CAP_IR: ir_shift_d = IR_CAP;
      SH_IR:  ir_shift_d = {tdi, ir_shift_q[IR_WIDTH-1:1]};
      UPD_IR: ir_d       = ir_shift_q;
      CAP_DR: begin
        if (byp_sel) bypass_d = 1'b0;
        if (id_sel)  id_d     = IDCODE | 32'h1;
      end
      SH_DR: begin
        if (byp_sel) bypass_d = tdi;
        if (id_sel)  id_d     = {tdi, id_q[31:1]};
      end
      default: ;
    endcase
  end

  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      state_q    <= TLR;
      ir_q       <= RST_OP;
      ir_shift_q <= '0;
      bypass_q   <= 1'b0;
      id_q       <= '0;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      ir_shift_q <= ir_shift_d;
      bypass_q   <= bypass_d;
      id_q       <= id_d;
    end
  end

  always_comb begin
    tdo_d    = tdo_q;
    tdo_en_d = 1'b0;
    if (state_q == SH_IR) begin
      tdo_d    = ir_shift_q[0];
      tdo_en_d = 1'b1;
    end else if (state_q == SH_DR) begin
      tdo_en_d = 1'b1;
      if (bsr_sel)     tdo_d = bsr_so;
      else if (id_sel) tdo_d = id_q[0];
      else             tdo_d = bypass_q;
    end
  end

  // Falling-edge launch gives the pin half a tck of setup before the host samples.
  always_ff @(negedge tck or negedge trst_n) begin
    if (!trst_n) begin
      tdo_q    <= 1'b0;
      tdo_en_q <= 1'b0;
    end else begin
      tdo_q    <= tdo_d;
      tdo_en_q <= tdo_en_d;
    end
  end

  assign tdo        = tdo_q;
  assign tdo_en     = tdo_en_q;
  assign capture_dr = bsr_sel && (state_q == CAP_DR);
  assign shift_dr   = bsr_sel && (state_q == SH_DR);
  assign update_dr  = bsr_sel && (state_q == UPD_DR);
  assign extest     = (ir_q == OP_EXTEST);
  assign intest     = (ir_q == OP_INTEST);

endmodule

// File: tb/tb_ehl_jtag_tap.sv
// Randomized and directed bench for ehl_jtag_tap against a table-driven TAP reference model.
module tb_ehl_jtag_tap;

  logic tck = 1'b0;
  logic trst_n, tms, tdi, bsr_so;
  logic tdo, tdo_en, capture_dr, shift_dr, update_dr, extest, intest;

  ehl_jtag_tap dut (
    .tck(tck), .trst_n(trst_n), .tms(tms), .tdi(tdi), .tdo(tdo), .tdo_en(tdo_en),
    .bsr_so(bsr_so), .capture_dr(capture_dr), .shift_dr(shift_dr), .update_dr(update_dr),
    .extest(extest), .intest(intest)
  );

  always #5 tck = ~tck;

`ifdef EHL_JTAG_IDCODE_EN
  localparam bit         ID_ON  = 1'b1;
  localparam logic [3:0] RST_OP = 4'h3;
`else
  localparam bit         ID_ON  = 1'b0;
  localparam logic [3:0] RST_OP = 4'hF;
`endif
  localparam logic [31:0] ID_VAL = 32'h1000_0001;

  // States: 0 TLR 1 RTI 2 SelDR 3 CapDR 4 ShDR 5 Ex1DR 6 PaDR 7 Ex2DR 8 UpdDR
  //         9 SelIR 10 CapIR 11 ShIR 12 Ex1IR 13 PaIR 14 Ex2IR 15 UpdIR
  localparam int NXT0 [16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
  localparam int NXT1 [16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};
  localparam int         PLEN  [16] = '{0, 1, 2, 3, 4, 4, 5, 6, 5, 3, 4, 5, 5, 6, 7, 6};
  localparam logic [7:0] PBITS [16] = '{8'd0, 8'd0, 8'd2, 8'd2, 8'd2, 8'd10, 8'd10, 8'd42,
                                        8'd26, 8'd6, 8'd6, 8'd6, 8'd22, 8'd22, 8'd86, 8'd54};

  int          m_st;
  logic [3:0]  m_ir, m_irsh;
  logic        m_byp, m_tdo, m_en;
  logic [31:0] m_id;
  int          total = 0;
  int          bad   = 0;

  wire [6:0] obs = {tdo, tdo_en, capture_dr, shift_dr, update_dr, extest, intest};

  function automatic logic [6:0] exp_vec();
    logic bsel;
    bsel = (m_ir == 4'h0) || (m_ir == 4'h1) || (m_ir == 4'h2);
    return {m_tdo, m_en, bsel && m_st == 3, bsel && m_st == 4, bsel && m_st == 8,
            m_ir == 4'h0, m_ir == 4'h2};
  endfunction

  function automatic void m_reset();
    m_st = 0; m_ir = RST_OP; m_irsh = 4'h0; m_byp = 1'b0;
    m_id = 32'h0; m_tdo = 1'b0; m_en = 1'b0;
  endfunction

  // One tck: drive inputs, advance the model at posedge, settle after negedge.
  task automatic step(input logic t_ms, input logic t_di);
    logic bsel, isel;
    tms = t_ms; tdi = t_di; bsr_so = 1'($urandom);
    @(posedge tck);
    case (m_st)
      0:  m_ir = RST_OP;
      3:  begin m_byp = 1'b0; m_id = ID_VAL | 32'h1; end
      4:  begin m_byp = t_di; m_id = (m_id >> 1) | (32'(t_di) << 31); end
      10: m_irsh = 4'h1;
      11: m_irsh = (m_irsh >> 1) | (4'(t_di) << 3);
      15: m_ir = m_irsh;
      default: ;
    endcase
    m_st = t_ms ? NXT1[m_st] : NXT0[m_st];
    @(negedge tck); #1;
    bsel = (m_ir == 4'h0) || (m_ir == 4'h1) || (m_ir == 4'h2);
    isel = ID_ON && (m_ir == 4'h3);
    if (m_st == 11) begin m_tdo = m_irsh[0]; m_en = 1'b1; end
    else if (m_st == 4) begin m_en = 1'b1; m_tdo = bsel ? bsr_so : (isel ? m_id[0] : m_byp); end
    else m_en = 1'b0;
  endtask

  task automatic goto_rti();
    repeat (5) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  task automatic scan_ir(input logic [3:0] v, output logic [3:0] o);
    step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      o[k] = tdo;
      step(k == 3, v[k]);
    end
    step(1'b1, 1'b0); step(1'b0, 1'b0);
  endtask

  task automatic scan_dr(input int n, input logic [31:0] din, output logic [31:0] dout, output int strobes);
    strobes = 0; dout = '0;
    step(1'b1, 1'b0); strobes += int'(capture_dr | shift_dr | update_dr);
    step(1'b0, 1'b0); strobes += int'(capture_dr | shift_dr | update_dr);
    step(1'b0, 1'b0); strobes += int'(capture_dr | shift_dr | update_dr);
    for (int k = 0; k < n; k++) begin
      dout[k] = tdo;
      step(k == n - 1, din[k]); strobes += int'(capture_dr | shift_dr | update_dr);
    end
    step(1'b1, 1'b0); strobes += int'(capture_dr | shift_dr | update_dr);
    step(1'b0, 1'b0); strobes += int'(capture_dr | shift_dr | update_dr);
  endtask

  task automatic test_reset();
    trst_n = 1'b0; tms = 1'b1; tdi = 1'b0; bsr_so = 1'b0;
    m_reset();
    repeat (2) @(negedge tck); #1;
    total++;
    if (obs !== 7'b0) begin bad++; $display("FAIL reset_outputs got=%b exp=%b", obs, 7'b0); end
    trst_n = 1'b1;
    step(1'b1, 1'b0);
    total++;
    if (obs !== exp_vec()) begin bad++; $display("FAIL reset_tlr_hold got=%b exp=%b", obs, exp_vec()); end
    step(1'b0, 1'b0);
    total++;
    if (obs !== exp_vec()) begin bad++; $display("FAIL reset_to_rti got=%b exp=%b", obs, exp_vec()); end
  endtask

  task automatic test_reset_mid_scan();
    logic [3:0] o;
    logic [31:0] dout, exp_d, din;
    int st;
    goto_rti();
    scan_ir(4'h0, o);
    step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    step(1'b0, 1'b1); step(1'b0, 1'b0);
    total++;
    if ({shift_dr, extest, tdo_en} !== 3'b111)
      begin bad++; $display("FAIL midscan_pre got=%b exp=%b", {shift_dr, extest, tdo_en}, 3'b111); end
    trst_n = 1'b0; #1; m_reset();
    total++;
    if ({tdo_en, extest, intest, shift_dr, capture_dr, update_dr} !== 6'b0)
      begin bad++; $display("FAIL midscan_async got=%b exp=%b", {tdo_en, extest, intest, shift_dr, capture_dr, update_dr}, 6'b0); end
    @(negedge tck); #1;
    total++;
    if (obs !== 7'b0) begin bad++; $display("FAIL midscan_held got=%b exp=%b", obs, 7'b0); end
    trst_n = 1'b1;
    // Partial IR shift interrupted by reset must never reach the instruction.
    step(1'b0, 1'b0); step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    step(1'b0, 1'b0); step(1'b0, 1'b0);
    trst_n = 1'b0; #1; m_reset();
    @(negedge tck); #1;
    trst_n = 1'b1;
    step(1'b0, 1'b0);
    total++;
    if ({extest, intest, update_dr} !== 3'b0)
      begin bad++; $display("FAIL midir_discard got=%b exp=%b", {extest, intest, update_dr}, 3'b0); end
    din = 32'($urandom);
    scan_dr(8, din, dout, st);
    exp_d = ID_ON ? (ID_VAL & 32'hFF) : {24'h0, din[6:0], 1'b0};
    total++;
    if (dout !== exp_d || st != 0)
      begin bad++; $display("FAIL midscan_reset_op got=%h/%0d exp=%h/0", dout, st, exp_d); end
  endtask

  task automatic test_all_states();
    for (int s = 0; s < 16; s++) begin
      logic [7:0] pb;
      pb = PBITS[s];
      repeat (5) step(1'b1, 1'($urandom));
      for (int k = 0; k < PLEN[s]; k++) step(pb[k], 1'($urandom));
      total++;
      if (obs !== exp_vec()) begin bad++; $display("FAIL state%0d_outputs got=%b exp=%b", s, obs, exp_vec()); end
      repeat (5) step(1'b1, 1'($urandom));
      total++;
      if ({tdo_en, capture_dr, shift_dr, update_dr} !== 4'b0)
        begin bad++; $display("FAIL state%0d_tlr got=%b exp=%b", s, {tdo_en, capture_dr, shift_dr, update_dr}, 4'b0); end
      step(1'b0, 1'b0);
      total++;
      if ({tdo_en, extest, intest} !== 3'b0)
        begin bad++; $display("FAIL state%0d_rti got=%b exp=%b", s, {tdo_en, extest, intest}, 3'b0); end
      step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
      total++;
      if ({tdo_en, shift_dr} !== 2'b10)
        begin bad++; $display("FAIL state%0d_shdr got=%b exp=%b", s, {tdo_en, shift_dr}, 2'b10); end
      step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0);
    end
  endtask

  task automatic test_idcode();
    logic [31:0] got, din, exp_d;
    trst_n = 1'b0; #1; m_reset();
    @(negedge tck); #1; trst_n = 1'b1;
    din = 32'($urandom);
    step(1'b0, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    for (int k = 0; k < 32; k++) begin
      got[k] = tdo;
      step(k == 31, din[k]);
    end
    step(1'b1, 1'b0); step(1'b0, 1'b0);
    exp_d = ID_ON ? ID_VAL : {din[30:0], 1'b0};
    total++;
    if (got !== exp_d) begin bad++; $display("FAIL idcode_stream got=%h exp=%h", got, exp_d); end
  endtask

  task automatic test_extest();
    logic [3:0] o;
    goto_rti();
    scan_ir(4'h0, o);
    total++;
    if (o !== 4'b0001) begin bad++; $display("FAIL extest_ir_out got=%b exp=%b", o, 4'b0001); end
    total++;
    if ({extest, intest} !== 2'b10) begin bad++; $display("FAIL extest_decode got=%b exp=%b", {extest, intest}, 2'b10); end
    step(1'b1, 1'b0); step(1'b0, 1'b0);
    total++;
    if ({capture_dr, shift_dr, update_dr} !== 3'b100)
      begin bad++; $display("FAIL extest_capture got=%b exp=%b", {capture_dr, shift_dr, update_dr}, 3'b100); end
    for (int k = 0; k < 6; k++) begin
      step(1'b0, 1'($urandom));
      total++;
      if ({shift_dr, tdo} !== {1'b1, bsr_so})
        begin bad++; $display("FAIL extest_shift%0d got=%b exp=%b", k, {shift_dr, tdo}, {1'b1, bsr_so}); end
    end
    step(1'b1, 1'b0); step(1'b1, 1'b0);
    total++;
    if ({capture_dr, shift_dr, update_dr, extest} !== 4'b0011)
      begin bad++; $display("FAIL extest_update got=%b exp=%b", {capture_dr, shift_dr, update_dr, extest}, 4'b0011); end
    step(1'b0, 1'b0);
    total++;
    if ({update_dr, extest} !== 2'b01) begin bad++; $display("FAIL extest_upd_once got=%b exp=%b", {update_dr, extest}, 2'b01); end
    scan_ir(4'h2, o);
    total++;
    if ({extest, intest} !== 2'b01) begin bad++; $display("FAIL intest_decode got=%b exp=%b", {extest, intest}, 2'b01); end
  endtask

  task automatic test_bypass();
    logic [3:0] o;
    logic [31:0] dout, din;
    int st;
    scan_ir(4'hF, o);
    scan_dr(4, 32'h0000_000D, dout, st);
    total++;
    if (dout[3:0] !== 4'b1010 || st != 0)
      begin bad++; $display("FAIL bypass_ones got=%b/%0d exp=1010/0", dout[3:0], st); end
    scan_ir(4'h3, o);
    din = 32'($urandom);
    scan_dr(8, din, dout, st);
    total++;
    if (dout[7:0] !== (ID_ON ? ID_VAL[7:0] : {din[6:0], 1'b0}) || st != 0)
      begin bad++; $display("FAIL ir3_select got=%h/%0d exp=%h/0", dout[7:0], st, (ID_ON ? ID_VAL[7:0] : {din[6:0], 1'b0})); end
  endtask

  task automatic test_random();
    int errs = 0;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 399) == 0) begin
        trst_n = 1'b0; #1; m_reset();
        @(negedge tck); #1; trst_n = 1'b1;
      end
      step($urandom_range(0, 3) == 0, 1'($urandom));
      total++;
      if (obs !== exp_vec()) begin
        bad++; errs++;
        if (errs <= 10) $display("FAIL random_cyc%0d got=%b exp=%b", c, obs, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_scan();
    test_all_states();
    test_idcode();
    test_extest();
    test_bypass();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
